// File: rtl/td4x_cpu_if.sv
// rtl/td4x_cpu_if.sv - instruction fetch bus between td4x_cpu and the program ROM
// The CPU drives the fetch address; the ROM side returns the instruction and its valid flag.
interface td4x_cpu_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  localparam int INSTR_W = 4 + DATA_W;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_valid;

  modport master (
    output imem_addr,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output imem_valid
  );
endinterface

// File: rtl/td4x_cpu.sv
// rtl/td4x_cpu.sv - single-cycle accumulator CPU with fetch stall, zero flag and OUT strobe
// One instruction retires per clock while imem_valid is high; HLT parks the core until reset.
module td4x_cpu #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  td4x_cpu_if.master        bus,
  input  logic [DATA_W-1:0] switch,
  output logic [DATA_W-1:0] led,
  output logic              out_strobe,
  output logic              halted
);
  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_SUB_A  = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_JZ     = 4'b1010;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_ADD_AB = 4'b1100;
  localparam logic [3:0] OP_HLT    = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic {RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [ADDR_W-1:0] ip_q, ip_d;
  logic              cf_q, cf_d, zf_q, zf_d;
  logic              out_strobe_q, out_strobe_d;
  logic              halted_q, halted_d;

  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] tgt, ip_inc;
  logic [DATA_W:0]   alu;

  assign op     = bus.imem_data[DATA_W+3:DATA_W];
  assign imm    = bus.imem_data[DATA_W-1:0];
  assign tgt    = imm[ADDR_W-1:0];
  assign ip_inc = ip_q + ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    out_d        = out_q;
    ip_d         = ip_q;
    cf_d         = cf_q;
    zf_d         = zf_q;
    out_strobe_d = 1'b0;
    alu          = '0;
    if (state_q == RUN && bus.imem_valid) begin
      // Flags only survive arithmetic; everything else retires with them cleared.
      ip_d = ip_inc;
      cf_d = 1'b0;
      zf_d = 1'b0;
      case (op)
        OP_ADD_A: begin
          alu  = {1'b0, a_q} + {1'b0, imm};
          a_d  = alu[DATA_W-1:0];
          cf_d = alu[DATA_W];
          zf_d = (alu[DATA_W-1:0] == '0);
        end
        OP_ADD_B: begin
          alu  = {1'b0, b_q} + {1'b0, imm};
          b_d  = alu[DATA_W-1:0];
          cf_d = alu[DATA_W];
          zf_d = (alu[DATA_W-1:0] == '0);
        end
        OP_ADD_AB: begin
          alu  = {1'b0, a_q} + {1'b0, b_q};
          a_d  = alu[DATA_W-1:0];
          cf_d = alu[DATA_W];
          zf_d = (alu[DATA_W-1:0] == '0);
        end
        OP_SUB_A: begin
          // The extra top bit of the widened difference is exactly the borrow.
          alu  = {1'b0, a_q} - {1'b0, imm};
          a_d  = alu[DATA_W-1:0];
          cf_d = alu[DATA_W];
          zf_d = (alu[DATA_W-1:0] == '0);
        end
        OP_MOV_A:  a_d = imm;
        OP_MOV_B:  b_d = imm;
        OP_MOV_AB: a_d = b_q;
        OP_MOV_BA: b_d = a_q;
        OP_IN_A:   a_d = switch;
        OP_IN_B:   b_d = switch;
        OP_OUT_B: begin
          out_d        = b_q;
          out_strobe_d = 1'b1;
        end
        OP_OUT_I: begin
          out_d        = imm;
          out_strobe_d = 1'b1;
        end
        OP_JMP: ip_d = tgt;
        OP_JNC: ip_d = cf_q ? ip_inc : tgt;
        OP_JZ:  ip_d = zf_q ? tgt : ip_inc;
        OP_HLT: begin
          ip_d    = ip_q;
          state_d = HALT;
        end
        default: ;
      endcase
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= RUN;
      a_q          <= '0;
      b_q          <= '0;
      out_q        <= '0;
      ip_q         <= '0;
      cf_q         <= 1'b0;
      zf_q         <= 1'b0;
      out_strobe_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_q        <= out_d;
      ip_q         <= ip_d;
      cf_q         <= cf_d;
      zf_q         <= zf_d;
      out_strobe_q <= out_strobe_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.imem_addr = ip_q;
  assign led           = out_q;
  assign out_strobe    = out_strobe_q;
  assign halted        = halted_q;
endmodule

// File: tb/tb_td4x_cpu.sv
// tb/tb_td4x_cpu.sv - directed-vector bench for td4x_cpu at DATA_W=4 and DATA_W=8
module tb_td4x_cpu;
  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       valid = 1'b1;
  logic [3:0] switch4 = '0;
  logic [7:0] switch8 = '0;
  logic [3:0] led4;
  logic [7:0] led8;
  logic       strobe4, strobe8, halted4, halted8;
  logic [7:0] rom4 [16];
  logic [11:0] rom8 [16];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  td4x_cpu_if #(.DATA_W(4), .ADDR_W(4)) if4 ();
  td4x_cpu_if #(.DATA_W(8), .ADDR_W(4)) if8 ();

  assign if4.imem_data  = rom4[if4.imem_addr];
  assign if4.imem_valid = valid;
  assign if8.imem_data  = rom8[if8.imem_addr];
  assign if8.imem_valid = valid;

  td4x_cpu #(.DATA_W(4), .ADDR_W(4)) u4 (
    .clk(clk), .n_reset(n_reset), .bus(if4.master), .switch(switch4),
    .led(led4), .out_strobe(strobe4), .halted(halted4)
  );
  td4x_cpu #(.DATA_W(8), .ADDR_W(4)) u8 (
    .clk(clk), .n_reset(n_reset), .bus(if8.master), .switch(switch8),
    .led(led8), .out_strobe(strobe8), .halted(halted8)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    valid = 1'b1;
    step();
    step();
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) rom4[i] = 8'h01;
    do_reset();
    total++; if (if4.imem_addr !== 4'd0) begin bad++; $display("FAIL reset_ip got=%0h exp=0", if4.imem_addr); end
    total++; if (led4 !== 4'd0) begin bad++; $display("FAIL reset_led got=%0h exp=0", led4); end
    total++; if (strobe4 !== 1'b0 || halted4 !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", strobe4, halted4); end
    total++; if (u4.a_q !== 4'd0 || u4.cf_q !== 1'b0 || u4.zf_q !== 1'b0) begin bad++; $display("FAIL reset_acc got=%0h/%b%b exp=0/00", u4.a_q, u4.cf_q, u4.zf_q); end
  endtask

  task automatic test_add_wrap();
    logic [3:0] ea;
    logic ec;
    for (int k = 1; k <= 16; k++) begin
      step();
      ea = 4'(k);
      ec = (k == 16);
      total++; if (u4.a_q !== ea || u4.cf_q !== ec || u4.zf_q !== ec) begin
        bad++; $display("FAIL add_wrap_%0d got=%0h/%b%b exp=%0h/%b%b", k, u4.a_q, u4.cf_q, u4.zf_q, ea, ec, ec);
      end
      total++; if (led4 !== 4'd0 || strobe4 !== 1'b0) begin bad++; $display("FAIL add_wrap_led_%0d got=%0h exp=0", k, led4); end
    end
    total++; if (if4.imem_addr !== 4'd0) begin bad++; $display("FAIL add_wrap_ip got=%0h exp=0", if4.imem_addr); end
    rom4[0] = 8'hE5;
    step();
    total++; if (if4.imem_addr !== 4'd1 || u4.cf_q !== 1'b0) begin bad++; $display("FAIL jnc_fallthrough got=%0h/%b exp=1/0", if4.imem_addr, u4.cf_q); end
  endtask

  task automatic test_wide_jz();
    int pulses = 0;
    rom8[0] = 12'h3FF; rom8[1] = 12'h001; rom8[2] = 12'hA05; rom8[3] = 12'hB11;
    rom8[4] = 12'hD00; rom8[5] = 12'hBAA; rom8[6] = 12'hD00;
    do_reset();
    step();
    total++; if (u8.a_q !== 8'hFF) begin bad++; $display("FAIL wide_mov got=%0h exp=ff", u8.a_q); end
    step();
    total++; if (u8.a_q !== 8'h00 || u8.cf_q !== 1'b1 || u8.zf_q !== 1'b1) begin bad++; $display("FAIL wide_add got=%0h/%b%b exp=0/11", u8.a_q, u8.cf_q, u8.zf_q); end
    step();
    total++; if (if8.imem_addr !== 4'd5) begin bad++; $display("FAIL wide_jz got=%0h exp=5", if8.imem_addr); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (strobe8) pulses++;
      total++; if (led8 === 8'h11) begin bad++; $display("FAIL wide_led_skip got=%0h exp=not 11", led8); end
    end
    total++; if (led8 !== 8'hAA) begin bad++; $display("FAIL wide_led got=%0h exp=aa", led8); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL wide_strobe_count got=%0d exp=1", pulses); end
    total++; if (halted8 !== 1'b1 || if8.imem_addr !== 4'd6) begin bad++; $display("FAIL wide_halt got=%b/%0h exp=1/6", halted8, if8.imem_addr); end
  endtask

  task automatic test_sub_borrow();
    rom8[0] = 12'h303; rom8[1] = 12'h805; rom8[2] = 12'hE00; rom8[3] = 12'hD00;
    do_reset();
    step();
    step();
    total++; if (u8.a_q !== 8'hFE || u8.cf_q !== 1'b1 || u8.zf_q !== 1'b0) begin bad++; $display("FAIL sub_borrow got=%0h/%b%b exp=fe/10", u8.a_q, u8.cf_q, u8.zf_q); end
    step();
    total++; if (if8.imem_addr !== 4'd3) begin bad++; $display("FAIL sub_jnc got=%0h exp=3", if8.imem_addr); end
  endtask

  task automatic test_stall();
    rom8[0] = 12'h3F0; rom8[1] = 12'h020; rom8[2] = 12'hE07; rom8[3] = 12'hD00;
    do_reset();
    step();
    step();
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (u8.a_q !== 8'h10 || u8.b_q !== 8'h00 || u8.cf_q !== 1'b1 || u8.zf_q !== 1'b0) begin
        bad++; $display("FAIL stall_regs_%0d got=%0h/%0h/%b%b exp=10/0/10", i, u8.a_q, u8.b_q, u8.cf_q, u8.zf_q);
      end
      total++; if (if8.imem_addr !== 4'd2 || led8 !== 8'h00 || strobe8 !== 1'b0) begin
        bad++; $display("FAIL stall_io_%0d got=%0h/%0h/%b exp=2/0/0", i, if8.imem_addr, led8, strobe8);
      end
    end
    valid = 1'b1;
    step();
    total++; if (if8.imem_addr !== 4'd3) begin bad++; $display("FAIL stall_jnc got=%0h exp=3", if8.imem_addr); end
    valid = 1'b0;
    step();
    step();
    total++; if (halted8 !== 1'b0) begin bad++; $display("FAIL stall_hlt got=%b exp=0", halted8); end
    valid = 1'b1;
    step();
    total++; if (halted8 !== 1'b1 || if8.imem_addr !== 4'd3) begin bad++; $display("FAIL hlt_after_stall got=%b/%0h exp=1/3", halted8, if8.imem_addr); end
  endtask

  task automatic test_halt_reset();
    switch8 = 8'h5A;
    rom8[0] = 12'h600; rom8[1] = 12'h900; rom8[2] = 12'hD00;
    do_reset();
    step();
    step();
    total++; if (strobe8 !== 1'b1 || led8 !== 8'h5A) begin bad++; $display("FAIL out_b got=%b/%0h exp=1/5a", strobe8, led8); end
    step();
    for (int i = 0; i < 20; i++) begin
      valid = (i % 3 != 0);
      step();
      total++; if (halted8 !== 1'b1 || if8.imem_addr !== 4'd2 || strobe8 !== 1'b0 || led8 !== 8'h5A) begin
        bad++; $display("FAIL halt_hold_%0d got=%b/%0h/%b/%0h exp=1/2/0/5a", i, halted8, if8.imem_addr, strobe8, led8);
      end
    end
    n_reset = 1'b0;
    step();
    n_reset = 1'b1;
    total++; if (if8.imem_addr !== 4'd0 || halted8 !== 1'b0 || led8 !== 8'h00) begin
      bad++; $display("FAIL halt_reset got=%0h/%b/%0h exp=0/0/0", if8.imem_addr, halted8, led8);
    end
    valid = 1'b1;
  endtask

  task automatic test_ip_wrap();
    for (int i = 0; i < 16; i++) rom4[i] = 8'h30;
    do_reset();
    for (int i = 0; i < 15; i++) step();
    total++; if (if4.imem_addr !== 4'd15) begin bad++; $display("FAIL ip_pre_wrap got=%0h exp=f", if4.imem_addr); end
    step();
    total++; if (if4.imem_addr !== 4'd0) begin bad++; $display("FAIL ip_wrap got=%0h exp=0", if4.imem_addr); end
  endtask

  task automatic test_back_to_back();
    rom4[0] = 8'h39; rom4[1] = 8'h77; rom4[2] = 8'hC0; rom4[3] = 8'h40;
    rom4[4] = 8'hB3; rom4[5] = 8'hB5; rom4[6] = 8'hD0;
    do_reset();
    step();
    step();
    step();
    total++; if (u4.a_q !== 4'd0 || u4.cf_q !== 1'b1 || u4.zf_q !== 1'b1) begin bad++; $display("FAIL add_ab got=%0h/%b%b exp=0/11", u4.a_q, u4.cf_q, u4.zf_q); end
    step();
    total++; if (u4.b_q !== 4'd0 || u4.cf_q !== 1'b0 || u4.zf_q !== 1'b0) begin bad++; $display("FAIL mov_ba got=%0h/%b%b exp=0/00", u4.b_q, u4.cf_q, u4.zf_q); end
    step();
    total++; if (strobe4 !== 1'b1 || led4 !== 4'd3) begin bad++; $display("FAIL b2b_first got=%b/%0h exp=1/3", strobe4, led4); end
    step();
    total++; if (strobe4 !== 1'b1 || led4 !== 4'd5) begin bad++; $display("FAIL b2b_second got=%b/%0h exp=1/5", strobe4, led4); end
    step();
    total++; if (strobe4 !== 1'b0 || halted4 !== 1'b1) begin bad++; $display("FAIL b2b_end got=%b/%b exp=0/1", strobe4, halted4); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom4[i] = 8'hD0;
      rom8[i] = 12'hD00;
    end
    test_reset();
    test_add_wrap();
    test_wide_jz();
    test_sub_borrow();
    test_stall();
    test_halt_reset();
    test_ip_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/td4x_cpu.md
Name: td4x_cpu

Overview:
- Parametrised next-generation single-cycle accumulator CPU. Data path width and program address width are configurable.
- Adds three features to the base machine:
  - a fetch-valid stall handshake;
  - a zero flag with JZ, SUB A,IMM, ADD A,B and HLT, filling all 16 opcodes;
  - an output-write strobe.
- Sits on the mother board between the program ROM, the input switches and the LED output latch.

Parameters:
- DATA_W, 4: width of registers A, B, OUT, the immediate field, switch and led. Legal range 4..16.
- ADDR_W, 4: width of the instruction pointer and imem_addr. Must satisfy ADDR_W <= DATA_W.
- INSTR_W, 4+DATA_W: derived, not overridable. The instruction is {opcode[3:0], imm[DATA_W-1:0]}.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- n_reset  input  1  synchronous, active-low reset.
- imem_addr  output  ADDR_W  fetch address; equals ip.
- imem_data  input  INSTR_W  instruction at imem_addr.
- imem_valid  input  1  imem_data is valid this cycle; when low the CPU stalls.
- switch  input  DATA_W  value read by IN instructions.
- led  output  DATA_W  OUT register.
- out_strobe  output  1  registered 1-cycle pulse, the cycle after an OUT instruction executes.
- halted  output  1  high while in the HALT state.

Behaviour:
- State is a, b, out (DATA_W each), cf, zf, ip (ADDR_W), out_strobe and FSM {RUN, HALT}.
- Reset (n_reset=0 at a rising clk edge) forces a=b=out=0, cf=zf=0, ip=0, out_strobe=0, state=RUN, and therefore halted=0.
  - Reset has priority over every other condition, including HALT and stalls.
- RUN state: an instruction executes when imem_valid=1 at a clock edge.
  - Single-cycle execution.
  - Default next_ip = ip+1, modulo 2^ADDR_W, so ip wraps from 2^ADDR_W-1 to 0.
- RUN stall: imem_valid=0 means all architectural state holds, including cf and zf, and out_strobe=0.
- HALT state: all state holds and imem_valid is ignored. Only reset leaves HALT. In HALT, halted=1 and out_strobe=0.
- Opcodes (binary, imm = instr[DATA_W-1:0], tgt = imm[ADDR_W-1:0]):
  - 0000 ADD A,imm: {cf,a}=a+imm.
  - 0101 ADD B,imm: {cf,b}=b+imm.
  - 1100 ADD A,B: {cf,a}=a+b.
  - 1000 SUB A,imm: a=a-imm modulo 2^DATA_W; cf=1 iff imm>a (borrow).
  - 0011 MOV A,imm. 0111 MOV B,imm. 0001 MOV A,B. 0100 MOV B,A.
  - 0010 IN A: a=switch. 0110 IN B: b=switch.
  - 1001 OUT B: out=b. 1011 OUT imm: out=imm.
  - 1111 JMP: ip=tgt.
  - 1110 JNC: ip = cf ? ip+1 : tgt.
  - 1010 JZ: ip = zf ? tgt : ip+1.
  - 1101 HLT: state goes to HALT and ip holds (not incremented).
- Flags:
  - ADD, ADD A,B and SUB set cf as defined above, and set zf=1 iff the DATA_W-bit result is 0.
  - Every other executed instruction (including jumps, OUT, MOV, IN and HLT) clears cf and zf to 0.
  - A conditional jump therefore tests the flags of the immediately preceding executed instruction. Stalled cycles do not count.
- out_strobe is 1 for exactly the cycle after an edge that executed OUT B or OUT imm. Back-to-back OUTs give a continuous high strobe.
- Arithmetic is unsigned at DATA_W bits; the carry is bit DATA_W of the DATA_W+1-bit sum.
- An immediate wider than ADDR_W used as a jump target is truncated; upper bits are ignored.
- Combinational paths: imem_addr=ip and led=out are direct register outputs. There is no combinational path from any input to any output.
- Simultaneous events: a stall coinciding with HLT means the stall wins and HLT executes when imem_valid next rises. Reset during a stall or HALT resets as above.

Test Plan:
- Reset/defaults: DATA_W=4, ADDR_W=4. Program ADD A,1 ×16 then JNC. Required: a wraps 15→0 with cf=1 and zf=1 on the 16th ADD. The JNC then falls through (ip+1). led=0 throughout.
- Wide datapath: DATA_W=8. Program MOV A,0xFF; ADD A,0x01; JZ 5; OUT 0x11 at addr 3; OUT 0xAA at addr 5. Required: a=0x00, cf=1, zf=1, jump taken, led=0xAA, one out_strobe pulse, and led never 0x11.
- SUB borrow: DATA_W=8. Program MOV A,3; SUB A,5; JNC 0. Required: a=0xFE, cf=1, zf=0, the JNC is not taken, ip=3 after it.
- Stall: hold imem_valid=0 for 5 cycles mid-program after an ADD that set cf=1. Required: a, b, ip, out, cf and zf are unchanged over those cycles and out_strobe stays 0. After resume, the JNC sees cf=1.
- HLT and reset: program IN B; OUT B; HLT with switch=0x5A. Required:
  - led=0x5A and halted=1, with ip fixed at 2 for 20 cycles even when imem_valid toggles;
  - asserting n_reset=0 for one cycle then gives ip=0, halted=0, led=0;
  - ip wrap: with ADDR_W=4, 16 consecutive MOV A,0 instructions bring ip from 15 back to 0.
